// File: rtl/deserializer_pkg.sv
// deserializer_pkg
//   Shared types and constants for the serial-to-parallel byte receiver.
//   - deser_state_t       : receiver FSM state (RECEIVE, FULL)
//   - DESER_DEFAULT_WIDTH : default word width in bits
package deserializer_pkg;

  localparam int DESER_DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    RECEIVE = 1'b0,
    FULL    = 1'b1
  } deser_state_t;

endpackage : deserializer_pkg

// File: rtl/shift_reg_sipo.sv
// shift_reg_sipo
//   Serial-in parallel-out shift register, MSB first: each enabled edge
//   shifts the register left by one and inserts din at the LSB.
//   Ports:
//     clk     in   clock, rising edge
//     reset   in   synchronous active-high reset (clears the register)
//     clr     in   synchronous clear, has priority over en
//     en      in   shift enable
//     din     in   serial input bit
//     q_next  out  WIDTH-bit word the register would hold after a shift
//                  of din; lets the parent capture a completed word on the
//                  same edge that accepts its last bit
module shift_reg_sipo
  import deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Shifted word, regardless of enable.
  always_comb begin
    q_next = {shift_q[WIDTH-2:0], din};
  end

  // Next register value: clear, shift or hold.
  always_comb begin
    shift_d = shift_q;
    if (clr) begin
      shift_d = '0;
    end else if (en) begin
      shift_d = q_next;
    end else begin
      shift_d = shift_q;
    end
  end

  // Register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

endmodule : shift_reg_sipo

// File: rtl/byte_deserializer.sv
// byte_deserializer
//   Shifts in one bit per clock while write_in is high (MSB first) and
//   presents each completed word on data_out with data_ready held high
//   until ack_in. While a word is held, incoming bits are ignored.
//   Ports:
//     clk_100mhz  in   system clock, rising edge
//     reset       in   synchronous active-high reset
//     data_in     in   serial data bit
//     write_in    in   bit-valid strobe
//     ack_in      in   consumer acknowledge for the held word
//     data_out    out  last completed word (registered, kept after ack)
//     data_ready  out  unacknowledged word held (registered)
//     status_out  out  block can accept bits, always !data_ready (registered)
module byte_deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = DESER_DEFAULT_WIDTH
) (
  input  logic                  clk_100mhz,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  write_in,
  input  logic                  ack_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_ready,
  output logic                  status_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  deser_state_t          state_q,      state_d;
  logic [CNT_W-1:0]      bit_cnt_q,    bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
  logic                  data_ready_q, data_ready_d;
  logic                  status_q,     status_d;

  logic                  shift_en;
  logic                  shift_clr;
  logic [DATA_WIDTH-1:0] shift_next;

  shift_reg_sipo #(
    .WIDTH (DATA_WIDTH)
  ) u_shift (
    .clk    (clk_100mhz),
    .reset  (reset),
    .clr    (shift_clr),
    .en     (shift_en),
    .din    (data_in),
    .q_next (shift_next)
  );

  // FSM next-state, bit counter and output register updates.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    data_ready_d = data_ready_q;
    status_d     = status_q;
    shift_en     = 1'b0;
    shift_clr    = 1'b0;

    case (state_q)
      RECEIVE: begin
        if (write_in) begin
          if (bit_cnt_q == LAST_CNT) begin
            // Last bit: capture the word directly from the shift path and
            // clear the shifter so the next word starts from a clean slate.
            shift_clr    = 1'b1;
            data_out_d   = shift_next;
            data_ready_d = 1'b1;
            status_d     = 1'b0;
            bit_cnt_d    = '0;
            state_d      = FULL;
          end else begin
            shift_en  = 1'b1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      FULL: begin
        // Any write_in arriving with (or without) the ack is dropped here.
        if (ack_in) begin
          data_ready_d = 1'b0;
          status_d     = 1'b1;
          state_d      = RECEIVE;
        end else begin
          state_d = FULL;
        end
      end

      default: begin
        state_d      = RECEIVE;
        bit_cnt_d    = '0;
        data_ready_d = 1'b0;
        status_d     = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_q      <= RECEIVE;
      bit_cnt_q    <= '0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      status_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
      status_q     <= status_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;
  assign status_out = status_q;

endmodule : byte_deserializer

// File: tb/tb_byte_deserializer.sv
module tb_byte_deserializer;

  logic       clk_100mhz;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       ack_in;
  logic [7:0] data_out;
  logic       data_ready;
  logic       status_out;

  int errors;
  int checks;

  byte_deserializer #(.DATA_WIDTH(8)) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .ack_in     (ack_in),
    .data_out   (data_out),
    .data_ready (data_ready),
    .status_out (status_out)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    logic       rst;
    logic       din;
    logic       wr;
    logic       ack;
    logic       exp_ready;
    logic       exp_status;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic din, input logic wr,
                              input logic ack, input logic er, input logic [7:0] ed);
    vec_t v;
    v.rst = rst; v.din = din; v.wr = wr; v.ack = ack;
    v.exp_ready = er; v.exp_status = ~er; v.exp_data = ed;
    vecs.push_back(v);
  endfunction

  // Eight bits MSB first while receiving; data_out keeps prev until the 8th.
  function automatic void add_word(input logic [7:0] w, input logic [7:0] prev);
    logic [7:0] word;
    word = w;
    for (int i = 7; i >= 1; i--) add(1'b0, word[i], 1'b1, 1'b0, 1'b0, prev);
    add(1'b0, word[0], 1'b1, 1'b0, 1'b1, word);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic din, input logic wr, input logic ack);
    reset = rst; data_in = din; write_in = wr; ack_in = ack;
    @(posedge clk_100mhz);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0;

    // Reset
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // 0x55, then ack keeps data
    add_word(8'h55, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55);
    // Refill with 0x55, then 8 ones while FULL are ignored
    add_word(8'h55, 8'h55);
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55);
    add_word(8'hFF, 8'h55);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    // 4 ones, 3 idle cycles (one with a stray ack), then 4 zeros -> 0xF0
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0);
    // 4 ones, reset mid-word, then 0xA5 exactly
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hF0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    add_word(8'hA5, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].din, vecs[i].wr, vecs[i].ack);
      check($sformatf("v%0d data_ready", i), {7'd0, data_ready}, {7'd0, vecs[i].exp_ready});
      check($sformatf("v%0d status_out", i), {7'd0, status_out}, {7'd0, vecs[i].exp_status});
      check($sformatf("v%0d data_out", i), data_out, vecs[i].exp_data);
    end

    // Ack and write together while FULL: ack taken, bit dropped.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("collide data_ready", {7'd0, data_ready}, 8'h00);
    check("collide status_out", {7'd0, status_out}, 8'h01);
    check("collide data_out", data_out, 8'hA5);
    // 0x81 follows; a kept stray bit would misalign it.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("w81 ready before last bit", {7'd0, data_ready}, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("w81 data_ready", {7'd0, data_ready}, 8'h01);
    check("w81 status_out", {7'd0, status_out}, 8'h00);
    check("w81 data_out", data_out, 8'h81);
    // Hold without ack.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("hold data_ready", {7'd0, data_ready}, 8'h01);
    check("hold data_out", data_out, 8'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_byte_deserializer
